// File: rtl/keypad_digit_if.sv
// Keypad digit entry bundle: encoded key inputs and control in, BCD time entry out.
// Latency: none, signal grouping only.
// Backpressure: none; the receiver samples key inputs every cycle.
// Ports (via modports):
//   key_code[3:0], key_n, entry_en, clear       driven by the keypad/control side
//   timer_bcd[15:0], digit_count[2:0],
//   digit_strobe, key_held                      driven by the receiver
interface keypad_digit_if;
    logic [3:0]  key_code;
    logic        key_n;
    logic        entry_en;
    logic        clear;
    logic [15:0] timer_bcd;
    logic [2:0]  digit_count;
    logic        digit_strobe;
    logic        key_held;

    modport master (
        output key_code, key_n, entry_en, clear,
        input  timer_bcd, digit_count, digit_strobe, key_held
    );

    modport slave (
        input  key_code, key_n, entry_en, clear,
        output timer_bcd, digit_count, digit_strobe, key_held
    );
endinterface

// File: rtl/keypad_digit_receiver.sv
// Synchronizes and debounces an encoded keypad press and shifts each accepted BCD digit into an MM:SS entry.
// Latency: key_n low before edge 1 -> digit_strobe high after edge DEBOUNCE_CYCLES+3; entry updates one edge later.
// Backpressure: none; presses are ignored while entry_en=0 and a held key never repeats.
// Ports:
//   clk, rst  rising-edge clock, synchronous active-high reset
//   kp        keypad_digit_if.slave: key_code/key_n/entry_en/clear in,
//             timer_bcd/digit_count/digit_strobe/key_held out
module keypad_digit_receiver #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic           clk,
    input  logic           rst,
    keypad_digit_if.slave  kp
);
    localparam int               CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]    CNT_MAX = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        ACCEPT,
        HELD,
        REL_DB
    } state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;

    logic           key_n_m, key_n_s;
    logic [3:0]     code_m, code_s;
    logic [15:0]    timer_q;
    logic [2:0]     count_q;

    // Two-flop synchronizers; key_n idles high so reset leaves "no key".
    always_ff @(posedge clk) begin
        if (rst) begin
            key_n_m <= 1'b1;
            key_n_s <= 1'b1;
            code_m  <= 4'd0;
            code_s  <= 4'd0;
        end else begin
            key_n_m <= kp.key_n;
            key_n_s <= key_n_m;
            code_m  <= kp.key_code;
            code_s  <= code_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (!key_n_s && kp.entry_en) begin
                    state_nxt = PRESS_DB;
                    cnt_nxt   = CW'(1);
                end
            end
            PRESS_DB: begin
                // Dropping entry_en mid-debounce abandons the press entirely.
                if (key_n_s || !kp.entry_en) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = ACCEPT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ACCEPT: begin
                state_nxt = HELD;
            end
            HELD: begin
                // Key changes while held are ignored; only a release matters.
                if (key_n_s) begin
                    state_nxt = REL_DB;
                    cnt_nxt   = CW'(1);
                end
            end
            REL_DB: begin
                if (!key_n_s) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Entry register: clear outranks a coincident accept. Non-BCD codes
    // (A..F) still strobe but leave the entry untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= 16'd0;
            count_q <= 3'd0;
        end else if (kp.clear) begin
            timer_q <= 16'd0;
            count_q <= 3'd0;
        end else if (state == ACCEPT && code_s <= 4'd9) begin
            timer_q <= {timer_q[11:0], code_s};
            if (count_q != 3'd4) begin
                count_q <= count_q + 3'd1;
            end
        end
    end

    assign kp.timer_bcd    = timer_q;
    assign kp.digit_count  = count_q;
    assign kp.digit_strobe = (state == ACCEPT);
    assign kp.key_held     = (state == HELD) || (state == REL_DB);
endmodule

// File: tb/tb_keypad_digit_receiver.sv
// Self-checking bench for keypad_digit_receiver with DEBOUNCE_CYCLES=4.
// Latency: n/a.
// Backpressure: n/a.
module tb_keypad_digit_receiver;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    keypad_digit_if kp();

    keypad_digit_receiver #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobes = 0;
    int strobe_cyc = -1;

    // Reference entry: digits typed so far, kept as an integer MM:SS value
    // where each new digit multiplies by 16 and only the last four survive.
    int m_timer = 0;
    int m_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (kp.digit_strobe === 1'b1) begin
            strobes    = strobes + 1;
            strobe_cyc = cyc;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input int code);
        if (code <= 9) begin
            m_timer = (m_timer * 16 + code) % 65536;
            m_count = (m_count < 4) ? m_count + 1 : 4;
        end
    endtask

    task automatic model_clear();
        m_timer = 0;
        m_count = 0;
    endtask

    task automatic check_entry(input string tag);
        check({tag, "_timer"}, 32'(kp.timer_bcd), 32'(m_timer));
        check({tag, "_count"}, 32'(kp.digit_count), 32'(m_count));
    endtask

    // One physical press with optional contact bounce on press and release.
    task automatic press(input int code, input bit bounce, input bit rel_bounce);
        int s0;
        s0 = strobes;
        kp.key_code = 4'(code);
        if (bounce) begin
            kp.key_n = 1'b0;
            step($urandom_range(1, DB - 1));
            kp.key_n = 1'b1;
            step($urandom_range(1, 2));
        end
        kp.key_n = 1'b0;
        step(15);
        check("press_held", 32'(kp.key_held), 32'd1);
        kp.key_code = 4'($urandom);
        step(5);
        kp.key_n = 1'b1;
        if (rel_bounce) begin
            step($urandom_range(1, DB - 1));
            kp.key_n = 1'b0;
            step(2);
            kp.key_n = 1'b1;
        end
        step(12);
        model_accept(code);
        check("press_strobe_once", 32'(strobes - s0), 32'd1);
        check("press_released", 32'(kp.key_held), 32'd0);
        check_entry("press");
    endtask

    initial begin
        int t0;
        int s0;
        kp.key_n    = 1'b1;
        kp.key_code = 4'd0;
        kp.entry_en = 1'b1;
        kp.clear    = 1'b0;
        rst         = 1'b1;
        step(3);
        check("rst_timer", 32'(kp.timer_bcd), 32'd0);
        check("rst_count", 32'(kp.digit_count), 32'd0);
        check("rst_strobe", 32'(kp.digit_strobe), 32'd0);
        check("rst_held", 32'(kp.key_held), 32'd0);
        rst = 1'b0;
        step(2);

        // Clean press '5' with exact latency.
        t0 = cyc;
        kp.key_code = 4'd5;
        kp.key_n    = 1'b0;
        step(20);
        check("lat_strobe_cycle", 32'(strobe_cyc - t0), 32'(DB + 3));
        check("lat_strobe_count", 32'(strobes), 32'd1);
        check("lat_timer", 32'(kp.timer_bcd), 32'h0005);
        check("lat_count", 32'(kp.digit_count), 32'd1);
        check("lat_held", 32'(kp.key_held), 32'd1);
        kp.key_n = 1'b1;
        step(12);
        check("lat_released", 32'(kp.key_held), 32'd0);
        model_accept(5);

        // Plain clear pulse.
        kp.clear = 1'b1;
        step(1);
        kp.clear = 1'b0;
        model_clear();
        check_entry("clear");

        // Sequence 1,2,3,0 then overflow with 9.
        press(1, 1'b1, 1'b0);
        press(2, 1'b0, 1'b1);
        press(3, 1'b1, 1'b1);
        press(0, 1'b0, 1'b0);
        check("seq_1230", 32'(kp.timer_bcd), 32'h1230);
        press(9, 1'b1, 1'b0);
        check("seq_overflow", 32'(kp.timer_bcd), 32'h2309);
        check("seq_count_sat", 32'(kp.digit_count), 32'd4);

        // Press while entry disabled: nothing accepted.
        s0 = strobes;
        kp.entry_en = 1'b0;
        kp.key_code = 4'd8;
        kp.key_n    = 1'b0;
        step(20);
        kp.key_n = 1'b1;
        step(12);
        kp.entry_en = 1'b1;
        check("dis_no_strobe", 32'(strobes - s0), 32'd0);
        check_entry("dis");

        // entry_en drops during press debounce: aborted.
        kp.key_code = 4'd6;
        kp.key_n    = 1'b0;
        step(4);
        kp.entry_en = 1'b0;
        step(16);
        kp.key_n = 1'b1;
        step(12);
        kp.entry_en = 1'b1;
        check("abort_no_strobe", 32'(strobes - s0), 32'd0);
        check_entry("abort");

        // entry_en toggled while held: no re-accept.
        kp.key_code = 4'd4;
        kp.key_n    = 1'b0;
        step(12);
        kp.entry_en = 1'b0;
        step(4);
        kp.entry_en = 1'b1;
        step(10);
        check("toggle_one_strobe", 32'(strobes - s0), 32'd1);
        kp.key_n = 1'b1;
        step(12);
        model_accept(4);
        check_entry("toggle");

        // clear coincident with ACCEPT of '7' over prior 0x0012.
        kp.clear = 1'b1;
        step(1);
        kp.clear = 1'b0;
        model_clear();
        press(1, 1'b0, 1'b0);
        press(2, 1'b0, 1'b0);
        check("pre_clear_0012", 32'(kp.timer_bcd), 32'h0012);
        s0 = strobes;
        kp.key_code = 4'd7;
        kp.key_n    = 1'b0;
        step(DB + 3);
        check("coinc_strobe", 32'(kp.digit_strobe), 32'd1);
        kp.clear = 1'b1;
        step(1);
        kp.clear = 1'b0;
        check("coinc_timer", 32'(kp.timer_bcd), 32'd0);
        check("coinc_count", 32'(kp.digit_count), 32'd0);
        step(10);
        kp.key_n = 1'b1;
        step(12);
        check("coinc_one_strobe", 32'(strobes - s0), 32'd1);
        model_clear();

        // Randomized presses including non-BCD codes and bounce.
        for (int i = 0; i < 16; i++) begin
            press(int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
        end

        // Reset while held: outputs clear, key re-accepted once.
        kp.key_code = 4'd6;
        kp.key_n    = 1'b0;
        step(12);
        model_accept(6);
        check_entry("pre_rst");
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("hrst_timer", 32'(kp.timer_bcd), 32'd0);
        check("hrst_count", 32'(kp.digit_count), 32'd0);
        check("hrst_strobe", 32'(kp.digit_strobe), 32'd0);
        check("hrst_held", 32'(kp.key_held), 32'd0);
        model_clear();
        s0 = strobes;
        step(20);
        check("hrst_reaccept", 32'(strobes - s0), 32'd1);
        model_accept(6);
        check_entry("hrst");
        kp.key_n = 1'b1;
        step(12);
        check("hrst_released", 32'(kp.key_held), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
